// File: rtl/mod_mult_sequencer.sv
// rtl/mod_mult_sequencer.sv - sequential (A*B) mod (2^N-K) by MSB-first double-and-add
// One modular addition per cycle through a shared combinational modular adder.

module ParallelPrefixModularAdder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] k,
  output logic [N-1:0] o
);
  logic [N:0]   sum;
  logic [N+1:0] sum_k;

  // a,b < M so a+b < 2M; a+b >= M exactly when a+b+K carries into bit N.
  assign sum   = {1'b0, a} + {1'b0, b};
  assign sum_k = {1'b0, sum} + {2'b00, k};
  assign o     = (sum_k[N+1] | sum_k[N]) ? sum_k[N-1:0] : sum[N-1:0];
endmodule

module mod_mult_sequencer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_k,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_p,
  output logic         out_err
);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {S_IDLE, S_DOUBLE, S_ADD, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d, k_q, k_d, acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic [N-1:0]  add_b, add_o;
  logic [N:0]    modulus;
  logic          illegal;

  ParallelPrefixModularAdder #(.N(N)) u_adder (
    .a (acc_q),
    .b (add_b),
    .k (k_q),
    .o (add_o)
  );

  assign add_b = (state_q == S_DOUBLE) ? acc_q : a_q;

  assign modulus = {1'b1, {N{1'b0}}} - {1'b0, in_k};
  assign illegal = ({1'b0, in_a} >= modulus) | ({1'b0, in_b} >= modulus) |
                   (in_k < N'(3)) | in_k[N-1];

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_err   = (state_q == S_DONE) & err_q;
  assign out_p     = ((state_q == S_DONE) && !err_q) ? acc_q : '0;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          k_d     = in_k;
          acc_d   = '0;
          cnt_d   = CW'(N);
          err_d   = illegal;
          state_d = S_DOUBLE;
        end
      end
      S_DOUBLE: begin
        acc_d   = add_o;
        state_d = S_ADD;
      end
      S_ADD: begin
        if (b_q[N-1]) acc_d = add_o;
        b_d     = {b_q[N-2:0], 1'b0};
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? S_DONE : S_DOUBLE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
endmodule
